// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Sequencing controller for the stopwatch datapath. Turns two
//             debounced button levels into run / clear / clock-enable-restart
//             controls, runs the split (frozen display) mode, stores lap
//             times and selects which digit vector the display shows.
//  Ports    : clk          system clock, rising edge
//             reset        synchronous, active-high
//             btn_ss       start/stop button level
//             btn_lap      lap/reset button level
//             live_digits  live 5-digit BCD count (digit 0 in [3:0])
//             run          digit counter may increment
//             clear        1-cycle pulse, clear digit counter
//             ce_restart   1-cycle pulse, restart increment clock enable
//             show_digits  digits routed to the display mux
//             lap_idx      recalled lap slot (0 outside recall)
//             lap_count    number of stored laps
//             lap_full     lap buffer full
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int LAP_DEPTH  = 4,
    parameter int SPLIT_HOLD = 200_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic [19:0] live_digits,
    output logic        run,
    output logic        clear,
    output logic        ce_restart,
    output logic [19:0] show_digits,
    output logic [2:0]  lap_idx,
    output logic [2:0]  lap_count,
    output logic        lap_full
);

    // $clog2(N) bits always hold N-1, the largest value the timer loads.
    localparam int                   c_timer_w    = $clog2(SPLIT_HOLD);
    localparam logic [c_timer_w-1:0] c_timer_load = c_timer_w'(SPLIT_HOLD - 1);
    localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
    localparam logic [2:0]           c_lap_depth  = 3'(LAP_DEPTH);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_run     = 3'd1;
    localparam logic [2:0] c_st_split   = 3'd2;
    localparam logic [2:0] c_st_stopped = 3'd3;
    localparam logic [2:0] c_st_recall  = 3'd4;

    logic [2:0]           r_state;
    logic                 r_ss_prev;
    logic                 r_lap_prev;
    logic                 r_clear;
    logic                 r_ce_restart;
    logic [2:0]           r_lap_count;
    logic [2:0]           r_lap_idx;
    logic [c_timer_w-1:0] r_timer;
    logic [19:0]          r_hold;
    logic [19:0]          r_lap_mem [LAP_DEPTH];

    logic                 w_ss_press;
    logic                 w_lap_press;
    logic [2:0]           w_state_next;
    logic                 w_capture;
    logic                 w_store;
    logic [2:0]           w_lap_count_next;
    logic [2:0]           w_lap_idx_next;
    logic [c_timer_w-1:0] w_timer_next;
    logic                 w_clear_next;
    logic                 w_ce_restart_next;
    logic [19:0]          w_recall_digits;

    // Rising-edge detect; start/stop wins when both buttons press together.
    assign w_ss_press  = btn_ss & ~r_ss_prev;
    assign w_lap_press = btn_lap & ~r_lap_prev & ~w_ss_press;

    // A capture always refreshes the split display; it only lands in the
    // lap buffer while there is a free slot.
    assign w_store = w_capture && (r_lap_count < c_lap_depth);

    always_comb begin
        w_state_next      = r_state;
        w_capture         = 1'b0;
        w_lap_count_next  = r_lap_count;
        w_lap_idx_next    = 3'd0;
        w_timer_next      = '0;
        w_clear_next      = 1'b0;
        w_ce_restart_next = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_ss_press) begin
                    w_state_next      = c_st_run;
                    w_ce_restart_next = 1'b1;
                end else if (w_lap_press && (r_lap_count != 3'd0)) begin
                    w_state_next = c_st_recall;
                end
            end
            c_st_run, c_st_split: begin
                if (w_ss_press) begin
                    w_state_next = c_st_stopped;
                end else if (w_lap_press) begin
                    w_state_next = c_st_split;
                    w_capture    = 1'b1;
                    w_timer_next = c_timer_load;
                end else if (r_state == c_st_split) begin
                    if (r_timer == '0) begin
                        w_state_next = c_st_run;
                    end else begin
                        w_timer_next = r_timer - c_timer_one;
                    end
                end
            end
            c_st_stopped: begin
                if (w_ss_press) begin
                    w_state_next = c_st_run;
                end else if (w_lap_press) begin
                    w_state_next     = c_st_idle;
                    w_clear_next     = 1'b1;
                    w_lap_count_next = 3'd0;
                end
            end
            c_st_recall: begin
                w_lap_idx_next = r_lap_idx;
                if (w_ss_press) begin
                    w_state_next   = c_st_idle;
                    w_lap_idx_next = 3'd0;
                end else if (w_lap_press) begin
                    if (r_lap_idx + 3'd1 == r_lap_count) begin
                        w_state_next   = c_st_idle;
                        w_lap_idx_next = 3'd0;
                    end else begin
                        w_lap_idx_next = r_lap_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase

        if (w_store) begin
            w_lap_count_next = r_lap_count + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_clear      <= 1'b0;
            r_ce_restart <= 1'b0;
            r_lap_count  <= 3'd0;
            r_lap_idx    <= 3'd0;
            r_timer      <= '0;
            r_hold       <= '0;
            // Load current levels so a button held through reset is no press.
            r_ss_prev    <= btn_ss;
            r_lap_prev   <= btn_lap;
        end else begin
            r_state      <= w_state_next;
            r_clear      <= w_clear_next;
            r_ce_restart <= w_ce_restart_next;
            r_lap_count  <= w_lap_count_next;
            r_lap_idx    <= w_lap_idx_next;
            r_timer      <= w_timer_next;
            r_ss_prev    <= btn_ss;
            r_lap_prev   <= btn_lap;
            if (w_capture) begin
                r_hold <= live_digits;
            end
        end
    end

    // Lap storage carries no reset; slots above lap_count are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (!reset && w_store && (r_lap_count == 3'(i))) begin
                r_lap_mem[i] <= live_digits;
            end
        end
    end

    always_comb begin
        w_recall_digits = '0;
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (r_lap_idx == 3'(i)) begin
                w_recall_digits = r_lap_mem[i];
            end
        end
    end

    always_comb begin
        case (r_state)
            c_st_split:  show_digits = r_hold;
            c_st_recall: show_digits = w_recall_digits;
            default:     show_digits = live_digits;
        endcase
    end

    assign run        = (r_state == c_st_run) || (r_state == c_st_split);
    assign clear      = r_clear;
    assign ce_restart = r_ce_restart;
    assign lap_idx    = r_lap_idx;
    assign lap_count  = r_lap_count;
    assign lap_full   = (r_lap_count == c_lap_depth);

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the stopwatch datapath: the BCD digit counter, its increment clock enable and the 7-segment display mux.
- Takes two debounced button levels (start/stop, lap/reset) and produces the run, clear and clock-enable-restart controls.
- Runs a split (frozen display) mode and stores lap times in a small buffer.
- Selects which 20-bit digit vector the display shows: live count, split hold or recalled lap.

Parameters:
- LAP_DEPTH, 4, number of lap slots; legal range 1..7.
- SPLIT_HOLD, 200_000_000, clk cycles the split value stays frozen on the display (2 s at 100 MHz); must be ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_ss  in  1  debounced start/stop level, active-high.
- btn_lap  in  1  debounced lap/reset level, active-high.
- live_digits  in  20  live BCD count from the digit counter, 5×4 bits, digit 0 in [3:0].
- run  out  1  digit counter may increment while high.
- clear  out  1  one-cycle pulse: clear the digit counter.
- ce_restart  out  1  one-cycle pulse: reset the increment clock enable.
- show_digits  out  20  digits to send to the display mux.
- lap_idx  out  3  lap slot currently recalled; 0 outside RECALL.
- lap_count  out  3  number of stored laps.
- lap_full  out  1  high when lap_count == LAP_DEPTH.

Behaviour:
- Press detection
  - Registered previous level per button; press = level & ~prev.
  - A held button produces exactly one press.
  - If both buttons press in the same cycle, btn_ss wins and the lap press is discarded.
- State changes on the clk edge at the end of the press cycle. clear and ce_restart are registered and high for exactly the first cycle of the new state.
- States:
  - IDLE: run=0, show=live.
    - ss → RUN with ce_restart.
    - lap with lap_count>0 → RECALL, lap_idx=0.
    - lap with lap_count==0 → ignored.
  - RUN: run=1, show=live.
    - ss → STOPPED.
    - lap → capture live_digits (sampled in the press cycle) into hold_reg, and into lap_mem[lap_count] if not full (lap_count+1; if full the lap is dropped and the counter is unchanged) → SPLIT; hold timer loads SPLIT_HOLD-1.
  - SPLIT: run=1, show=hold_reg; timer decrements each cycle.
    - Timer at 0 → RUN.
    - lap → new capture, same rules as RUN; timer reloads.
    - ss → STOPPED; show=live from the next cycle.
  - STOPPED: run=0, show=live.
    - ss → RUN (resume, no ce_restart).
    - lap → IDLE with clear pulse; lap_count=0.
  - RECALL: run=0, show=lap_mem[lap_idx].
    - lap → lap_idx+1; when lap_idx==lap_count-1, go to IDLE (lap_idx=0).
    - ss → IDLE immediately.
    - lap_mem contents are preserved.
- Illegal state encoding → IDLE on the next edge.
- lap_mem is not reset; contents are meaningful only below lap_count. show_digits is a combinational mux on registered state and data.
- Reset, on any cycle including mid-SPLIT or mid-RECALL:
  - state=IDLE, run=0, clear=0, ce_restart=0, lap_count=0, lap_idx=0, timer=0, hold_reg=0.
  - Button prev registers are loaded with the current levels, so a button held through reset is not a press.
- Width rules: lap_count and lap_idx are 3-bit unsigned; the hold timer is wide enough for SPLIT_HOLD-1.

Test Plan:
- Bench parameters: LAP_DEPTH=2, SPLIT_HOLD=8.
- Reset, then ss press → next cycle ce_restart=1 for 1 cycle, run=1; holding ss 20 cycles gives no further transition.
- RUN, live=20'h00123, lap press → show=00123 for exactly 8 cycles while run stays 1, then show=live; lap_count=1.
- Three lap presses in RUN/SPLIT with live=00011, 00022, 00033 → lap_count=2, lap_full=1, third lap frozen on display but not stored.
- ss, then lap from STOPPED → clear pulse 1 cycle, lap_count=0, state IDLE, run=0.
- IDLE with 2 laps (00011, 00022): lap → show 00011, lap_idx=0; lap → 00022, lap_idx=1; lap → IDLE showing live; an ss press mid-recall → IDLE.
- Simultaneous ss+lap rising in RUN → STOPPED, no capture; reset asserted in SPLIT → all outputs at reset values next cycle.
